// File: rtl/wb_register_file_pkg.sv
// ============================================================================
// Module      : wb_register_file_pkg
// Description : Shared pipeline constants for the register file and its
//               read-port bypass logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_register_file_pkg;

  // Register and data-path width
  localparam int DATA_W = 32;

  // Register address width
  localparam int ADDR_W = 5;

  // Number of architectural registers
  localparam int NUM_REGS = 1 << ADDR_W;

  // Hard-wired zero register index
  localparam int unsigned REG_ZERO = 0;

endpackage : wb_register_file_pkg

`default_nettype wire

// File: rtl/wb_register_file_read_bypass.sv
// ============================================================================
// Module      : regfile_read_bypass
// Description : One read port's output selection. Register 0 is forced to
//               zero; a committing write to the addressed register is
//               forwarded in the same cycle; otherwise array data passes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_bypass
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_bypass_en,
  input  logic [ADDR_W-1:0] i_wr_address,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_address,
  input  logic [DATA_W-1:0] i_array_data,
  output logic [DATA_W-1:0] o_rd_data
);

  // Zero-forcing takes precedence, then write-through forwarding, then array.
  always_comb begin
    o_rd_data = i_array_data;
    if (i_rd_address == ADDR_W'(REG_ZERO)) begin
      o_rd_data = '0;
    end else if (i_bypass_en && (i_wr_address == i_rd_address)) begin
      o_rd_data = i_wr_data;
    end
  end

endmodule : regfile_read_bypass

`default_nettype wire

// File: rtl/wb_register_file.sv
// ============================================================================
// Module      : wb_register_file
// Description : Two-read / one-write pipeline register file with write-through
//               bypass, last-write observation registers and a commit counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W = wb_register_file_pkg::DATA_W,
  parameter int ADDR_W = wb_register_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write_ctrl,
  input  logic [ADDR_W-1:0] wb_reg_write_address,
  input  logic [DATA_W-1:0] wb_reg_write_data,
  input  logic [ADDR_W-1:0] rs_address,
  input  logic [ADDR_W-1:0] rt_address,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              last_wr_valid,
  output logic [ADDR_W-1:0] last_wr_address,
  output logic [DATA_W-1:0] last_wr_data,
  output logic [31:0]       wr_count
);

  localparam int c_NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [c_NUM_REGS];
  logic              r_last_wr_valid;
  logic [ADDR_W-1:0] r_last_wr_address;
  logic [DATA_W-1:0] r_last_wr_data;
  logic [31:0]       r_wr_count;

  logic              w_commit;
  logic              w_bypass_en;
  logic [DATA_W-1:0] w_rs_array;
  logic [DATA_W-1:0] w_rt_array;

  // Address test is gated by ctrl first so an unknown address with ctrl low
  // can never produce a commit.
  assign w_commit    = wb_reg_write_ctrl && (wb_reg_write_address != ADDR_W'(REG_ZERO));
  assign w_bypass_en = w_commit && !rst;

  assign w_rs_array = r_regs[rs_address];
  assign w_rt_array = r_regs[rt_address];

  // Register array: reset clears every entry and wins over a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[wb_reg_write_address] <= wb_reg_write_data;
    end
  end

  // Last-write observation: valid pulses per commit, address/data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_wr_valid   <= 1'b0;
      r_last_wr_address <= '0;
      r_last_wr_data    <= '0;
    end else begin
      r_last_wr_valid <= w_commit;
      if (w_commit) begin
        r_last_wr_address <= wb_reg_write_address;
        r_last_wr_data    <= wb_reg_write_data;
      end
    end
  end

  // Committed-write counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_wr_count <= r_wr_count + 32'd1;
    end
  end

  regfile_read_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rs_bypass (
    .i_bypass_en  (w_bypass_en),
    .i_wr_address (wb_reg_write_address),
    .i_wr_data    (wb_reg_write_data),
    .i_rd_address (rs_address),
    .i_array_data (w_rs_array),
    .o_rd_data    (rs_data)
  );

  regfile_read_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rt_bypass (
    .i_bypass_en  (w_bypass_en),
    .i_wr_address (wb_reg_write_address),
    .i_wr_data    (wb_reg_write_data),
    .i_rd_address (rt_address),
    .i_array_data (w_rt_array),
    .o_rd_data    (rt_data)
  );

  assign last_wr_valid   = r_last_wr_valid;
  assign last_wr_address = r_last_wr_address;
  assign last_wr_data    = r_last_wr_data;
  assign wr_count        = r_wr_count;

endmodule : wb_register_file

`default_nettype wire

// File: doc/wb_register_file.md
WB_REGISTER_FILE -- requirements
Module: wb_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width (2**ADDR_W registers).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wb_reg_write_ctrl  input  1  write-back write enable from the MEM/WB stage.
REQ-006 SHALL have port wb_reg_write_address  input  ADDR_W  write-back destination register.
REQ-007 SHALL have port wb_reg_write_data  input  DATA_W  write-back data.
REQ-008 SHALL have port rs_address  input  ADDR_W  read port A address.
REQ-009 SHALL have port rt_address  input  ADDR_W  read port B address.
REQ-010 SHALL have port rs_data  output  DATA_W  read port A data.
REQ-011 SHALL have port rt_data  output  DATA_W  read port B data.
REQ-012 SHALL have port last_wr_valid  output  1  a committed write occurred in the previous cycle.
REQ-013 SHALL have port last_wr_address  output  ADDR_W  address of that write.
REQ-014 SHALL have port last_wr_data  output  DATA_W  data of that write.
REQ-015 SHALL have port wr_count  output  32  count of committed writes.

Function
REQ-016 A write SHALL commit when wb_reg_write_ctrl=1 and wb_reg_write_address!=0, updating the register array at that rising edge.
REQ-017 Writes to register 0 SHALL be dropped; register 0 SHALL always read 0.
REQ-018 Read ports SHALL be combinational (zero-cycle latency) from the array.
REQ-019 A read SHALL return wb_reg_write_data in the same cycle when a committing write targets the same nonzero address (write-through bypass), independently for each port.
REQ-020 Both read ports SHALL be able to address the same register, and each SHALL receive identical data.
REQ-021 last_wr_valid/address/data SHALL register the committed write, one cycle latency; they SHALL hold their address/data and drop valid to 0 in cycles with no committed write.
REQ-022 wr_count SHALL increment by 1 per committed write and wrap from 0xFFFFFFFF to 0; dropped writes (address 0 or ctrl=0) SHALL NOT count.
REQ-023 X/unknown on wb_reg_write_address while ctrl=0 SHALL NOT alter any state.

Reset
REQ-024 When rst=1 at a rising edge, all registers, last_wr_valid, last_wr_address, last_wr_data and wr_count SHALL become 0.
REQ-025 Reset SHALL take priority over a simultaneous write; that write SHALL be lost and not counted.
REQ-026 Read ports SHALL stay combinational during reset; bypass SHALL be suppressed while rst=1.

Structure
REQ-027 DATA_W, ADDR_W, NUM_REGS and REG_ZERO constants SHALL live in the shared pipeline package.
REQ-028 The per-port bypass/zero-forcing logic SHALL be one sub-module, regfile_read_bypass, instantiated twice.

Verification
REQ-029 Reset, then read all 32 addresses on both ports -> all read 0; wr_count=0; last_wr_valid=0.
REQ-030 Write 0xDEADBEEF to r8, with rs_address=8 in the same cycle -> rs_data=0xDEADBEEF that cycle (bypass); next cycle rs_data=0xDEADBEEF from the array, last_wr_valid=1, last_wr_address=8, wr_count=1.
REQ-031 Write 0x12345678 to r0 -> rs_data(0)=0 same and next cycle; wr_count unchanged; last_wr_valid=0.
REQ-032 rs_address=rt_address=17 after writing 0xA5A5A5A5 -> both ports return 0xA5A5A5A5; a concurrent write of 0x5 to r17 -> both return 0x5.
REQ-033 Assert rst together with a write of 0x1 to r3 -> r3 reads 0, wr_count=0, last_wr_valid=0 after the edge.
REQ-034 Force wr_count to 0xFFFFFFFF via 2**32-1 writes (or backdoor) then one write -> wr_count=0.
